// File: rtl/iss_dispatch_pkg.sv
// iss_dispatch_pkg: shared types, FU class indices and bundle helpers for the register-read dispatch stage
package iss_dispatch_pkg;
  localparam int FU_ALU = 0;
  localparam int FU_LSU = 1;
  localparam int FU_BR  = 2;
  localparam int FU_MUL = 3;
  localparam int FU_DIV = 4;
  localparam int NFU    = 5;
  localparam int VBIT   = 15;
  typedef struct packed {
    logic [15:0]      opid;
    logic [NFU-1:0]   fu;
    logic [15:0]      prd;
    logic [1:0][15:0] prsa;
  } iss_bundle_t;
  typedef struct packed {
    logic [15:0]      opid;
    logic [NFU-1:0]   fu;
    logic [15:0]      prd;
    logic [1:0][15:0] prsa;
    logic [63:0]      rs1;
    logic [63:0]      rs2;
  } rr_bundle_t;
  function automatic rr_bundle_t to_rr(iss_bundle_t b, logic [63:0] a, logic [63:0] c);
    rr_bundle_t r;
    r.opid = b.opid;
    r.fu   = b.fu;
    r.prd  = b.prd;
    r.prsa = b.prsa;
    r.rs1  = a;
    r.rs2  = c;
    return r;
  endfunction
endpackage

// File: rtl/iss_dispatch_rr_lane.sv
// rr_lane: one register-read slot holding an issued op and its two operands, with writeback bypass
module rr_lane
  import iss_dispatch_pkg::*;
#(
  parameter int ewd = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      accept_i,
  input  logic                      consume_i,
  input  iss_bundle_t               bundle_i,
  input  logic [1:0][63:0]          prf_rdata_i,
  input  logic [ewd-1:0]            wb_valid_i,
  input  logic [ewd-1:0][15:0]      wb_prd_i,
  input  logic [ewd-1:0][63:0]      wb_data_i,
  output logic                      valid_o,
  output rr_bundle_t                rr_bundle_o
);
  iss_bundle_t      b_q;
  logic             v_q;
  logic             fresh_q;
  logic [1:0][63:0] opr_q;
  logic [1:0][63:0] opr_d;
  // operand: PRF data on the first cycle, held copy afterwards; lowest matching writeback lane overrides; x0 is zero
  always_comb begin
    opr_d = '0;
    for (int k = 0; k < 2; k++) begin
      opr_d[k] = fresh_q ? prf_rdata_i[k] : opr_q[k];
      for (int j = ewd - 1; j >= 0; j--)
        if (wb_valid_i[j] && wb_prd_i[j] == b_q.prsa[k]) opr_d[k] = wb_data_i[j];
      if (b_q.prsa[k] == '0) opr_d[k] = '0;
    end
  end
  // slot state: a new accept replaces the entry; consume or flush empties it; operands track bypass while held
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q     <= '0;
      v_q     <= 1'b0;
      fresh_q <= 1'b0;
      opr_q   <= '0;
    end else begin
      fresh_q <= accept_i;
      v_q     <= accept_i | (v_q & ~flush_i & ~consume_i);
      if (accept_i) b_q <= bundle_i;
      if (v_q) opr_q <= opr_d;
    end
  end
  assign valid_o     = v_q;
  assign rr_bundle_o = v_q ? to_rr(b_q, opr_d[0], opr_d[1]) : '0;
endmodule

// File: rtl/iss_dispatch.sv
// iss_dispatch: per-lane register-read stage between issue queue and execution, with divider occupancy tracking
module iss_dispatch
  import iss_dispatch_pkg::*;
#(
  parameter int iwd    = 4,
  parameter int ewd    = 4,
  parameter int divlat = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        redir_i,
  input  iss_bundle_t [iwd-1:0]       iss_bundle_i,
  output logic [iwd-1:0]              issue_o,
  output logic [NFU-1:0]              fu_ready_o,
  output logic [iwd-1:0][1:0][15:0]   prf_raddr_o,
  input  logic [iwd-1:0][1:0][63:0]   prf_rdata_i,
  input  logic [ewd-1:0]              wb_valid_i,
  input  logic [ewd-1:0][15:0]        wb_prd_i,
  input  logic [ewd-1:0][63:0]        wb_data_i,
  output rr_bundle_t [iwd-1:0]        rr_bundle_o,
  input  logic [iwd-1:0]              exe_ready_i
);
  localparam int CW = $clog2(divlat) + 1;
  logic [CW-1:0]  div_q;
  logic [CW-1:0]  div_d;
  logic [iwd-1:0] v;
  logic [iwd-1:0] free;
  logic [iwd-1:0] acc;
  logic           div_acc;
  logic           blk;
  assign free = ~v | exe_ready_i;
  // issue grant: slot free, no redirect, and no DIV presented on a lower lane (one DIV per cycle)
  always_comb begin
    issue_o = '0;
    acc     = '0;
    div_acc = 1'b0;
    blk     = 1'b0;
    for (int i = 0; i < iwd; i++) begin
      issue_o[i] = free[i] & ~redir_i & ~blk;
      acc[i]     = issue_o[i] & iss_bundle_i[i].opid[VBIT];
      div_acc    = div_acc | (acc[i] & iss_bundle_i[i].fu[FU_DIV]);
      blk        = blk | (iss_bundle_i[i].opid[VBIT] & iss_bundle_i[i].fu[FU_DIV]);
    end
  end
  // PRF addresses follow the issue bundle unconditionally
  always_comb begin
    prf_raddr_o = '0;
    for (int i = 0; i < iwd; i++) prf_raddr_o[i] = iss_bundle_i[i].prsa;
  end
  assign div_d      = div_acc ? CW'(divlat) : (div_q != '0 ? div_q - CW'(1) : '0);
  assign fu_ready_o = {(|free) & (div_q == '0), {(NFU - 1){|free}}};
  // divider occupancy keeps draining across redirects; only reset clears it
  always_ff @(posedge clk) begin
    if (rst) div_q <= '0;
    else div_q <= div_d;
  end
  for (genvar g = 0; g < iwd; g++) begin : g_lane
    rr_lane #(.ewd(ewd)) u_lane (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (redir_i),
      .accept_i    (acc[g]),
      .consume_i   (exe_ready_i[g]),
      .bundle_i    (iss_bundle_i[g]),
      .prf_rdata_i (prf_rdata_i[g]),
      .wb_valid_i  (wb_valid_i),
      .wb_prd_i    (wb_prd_i),
      .wb_data_i   (wb_data_i),
      .valid_o     (v[g]),
      .rr_bundle_o (rr_bundle_o[g])
    );
  end
endmodule

// File: tb/tb_iss_dispatch.sv
// tb_iss_dispatch: randomized scoreboard bench for iss_dispatch against a behavioural lane/divider model
module tb_iss_dispatch;
  import iss_dispatch_pkg::*;
  localparam int IWD = 4, EWD = 4, DIVLAT = 16, NCYC = 3000;
  logic clk = 1'b0;
  logic rst, redir;
  iss_bundle_t [IWD-1:0] iss;
  logic [IWD-1:0] issue, exe_ready;
  logic [NFU-1:0] fu_ready;
  logic [IWD-1:0][1:0][15:0] raddr;
  logic [IWD-1:0][1:0][63:0] rdata;
  logic [EWD-1:0] wbv;
  logic [EWD-1:0][15:0] wbp;
  logic [EWD-1:0][63:0] wbd;
  rr_bundle_t [IWD-1:0] rr;
  always #5 clk = ~clk;
  iss_dispatch #(.iwd(IWD), .ewd(EWD), .divlat(DIVLAT)) dut (
    .clk(clk), .rst(rst), .redir_i(redir), .iss_bundle_i(iss), .issue_o(issue),
    .fu_ready_o(fu_ready), .prf_raddr_o(raddr), .prf_rdata_i(rdata), .wb_valid_i(wbv),
    .wb_prd_i(wbp), .wb_data_i(wbd), .rr_bundle_o(rr), .exe_ready_i(exe_ready)
  );
  typedef struct {
    logic [IWD-1:0]            issue;
    logic [NFU-1:0]            fu_ready;
    logic [IWD-1:0][1:0][15:0] raddr;
  } ctrl_t;
  ctrl_t      ctrl_q[$];
  rr_bundle_t lane_q[IWD][$];
  int n_cmp = 0, n_bad = 0;
  // model: each held op carries the operand values it currently shows
  bit          m_valid[IWD];
  bit          m_acc[IWD];
  iss_bundle_t m_op[IWD];
  logic [63:0] m_base[IWD][2];
  logic [63:0] m_show[IWD][2];
  logic [63:0] pend[IWD][2];
  logic [63:0] prf_mem[8];
  int          div_left;
  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic model_edge();
    bit any_div;
    any_div = 0;
    if (rst) begin
      for (int i = 0; i < IWD; i++) m_valid[i] = 0;
      div_left = 0;
      return;
    end
    for (int i = 0; i < IWD; i++) begin
      if (m_acc[i]) begin
        m_valid[i] = 1;
        m_op[i] = iss[i];
        m_base[i][0] = pend[i][0];
        m_base[i][1] = pend[i][1];
        if (iss[i].fu[FU_DIV]) any_div = 1;
      end else if (m_valid[i] && (redir || exe_ready[i])) m_valid[i] = 0;
      else if (m_valid[i]) begin
        m_base[i][0] = m_show[i][0];
        m_base[i][1] = m_show[i][1];
      end
    end
    div_left = any_div ? DIVLAT : (div_left > 0 ? div_left - 1 : 0);
  endtask
  task automatic drive();
    rst = ($urandom_range(0, 299) == 0);
    redir = ($urandom_range(0, 24) == 0);
    for (int i = 0; i < IWD; i++) begin
      int r;
      rdata[i][0] = pend[i][0];
      rdata[i][1] = pend[i][1];
      exe_ready[i] = ($urandom_range(0, 9) < 6);
      r = $urandom_range(0, 9);
      iss[i].opid = {($urandom_range(0, 3) != 0), 15'($urandom)};
      iss[i].fu = 5'(1 << ((r < 9 || div_left != 0) ? r % 4 : FU_DIV));
      iss[i].prd = 16'($urandom_range(1, 7));
      iss[i].prsa[0] = 16'($urandom_range(0, 7));
      iss[i].prsa[1] = 16'($urandom_range(0, 7));
    end
    for (int j = 0; j < EWD; j++) begin
      wbv[j] = 1'($urandom_range(0, 1));
      wbp[j] = 16'($urandom_range(0, 7));
      wbd[j] = {$urandom, $urandom};
    end
    prf_mem[$urandom_range(0, 7)] = {$urandom, $urandom};
    for (int i = 0; i < IWD; i++) begin
      pend[i][0] = prf_mem[iss[i].prsa[0][2:0]];
      pend[i][1] = prf_mem[iss[i].prsa[1][2:0]];
    end
  endtask
  task automatic predict();
    ctrl_t c;
    bit blk, any_free;
    blk = 0;
    any_free = 0;
    for (int i = 0; i < IWD; i++) begin
      bit fr;
      fr = !m_valid[i] || exe_ready[i];
      any_free |= fr;
      c.issue[i] = !redir && !blk && fr;
      if (iss[i].opid[15] && iss[i].fu[FU_DIV]) blk = 1;
      m_acc[i] = c.issue[i] && iss[i].opid[15];
      c.raddr[i][0] = iss[i].prsa[0];
      c.raddr[i][1] = iss[i].prsa[1];
      if (m_valid[i]) begin
        rr_bundle_t e;
        for (int k = 0; k < 2; k++) begin
          logic [15:0] src;
          logic [63:0] val;
          src = m_op[i].prsa[k];
          val = m_base[i][k];
          for (int j = 0; j < EWD; j++)
            if (wbv[j] && wbp[j] == src) begin
              val = wbd[j];
              break;
            end
          m_show[i][k] = (src == 0) ? 64'h0 : val;
        end
        e.opid = m_op[i].opid;
        e.fu = m_op[i].fu;
        e.prd = m_op[i].prd;
        e.prsa = m_op[i].prsa;
        e.rs1 = m_show[i][0];
        e.rs2 = m_show[i][1];
        lane_q[i].push_back(e);
      end
    end
    c.fu_ready = {any_free && div_left == 0, {4{any_free}}};
    ctrl_q.push_back(c);
  endtask
  initial begin
    rst = 1; redir = 0; iss = '0; exe_ready = '0; wbv = '0; wbp = '0; wbd = '0; rdata = '0;
    div_left = 0;
    for (int m = 0; m < 8; m++) prf_mem[m] = {$urandom, $urandom};
    for (int i = 0; i < IWD; i++) begin
      m_valid[i] = 0; m_acc[i] = 0; pend[i][0] = '0; pend[i][1] = '0;
    end
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      model_edge();
      #1;
      if (c < 3) begin
        rst = (c == 0);
        redir = 0;
      end
      drive();
      if (c < 3) begin
        rst = (c == 0);
        redir = 0;
      end
      predict();
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < IWD; i++) chk($sformatf("lane%0d_leftover", i), 256'(lane_q[i].size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  // monitor: compare control outputs each cycle, pop a lane entry whenever the DUT shows a valid op
  initial forever begin
    @(negedge clk);
    if (ctrl_q.size() > 0) begin
      ctrl_t c;
      c = ctrl_q.pop_front();
      chk("issue", 256'(issue), 256'(c.issue));
      chk("fu_ready", 256'(fu_ready), 256'(c.fu_ready));
      chk("prf_raddr", 256'(raddr), 256'(c.raddr));
      for (int i = 0; i < IWD; i++) begin
        if (rr[i].opid[15]) begin
          if (lane_q[i].size() == 0) chk($sformatf("lane%0d_unexpected_valid", i), 256'(rr[i]), 256'(0));
          else chk($sformatf("lane%0d_rr", i), 256'(rr[i]), 256'(lane_q[i].pop_front()));
        end else begin
          chk($sformatf("lane%0d_idle_zero", i), 256'(rr[i]), 256'(0));
          if (lane_q[i].size() != 0) chk($sformatf("lane%0d_missing", i), 256'(rr[i]), 256'(lane_q[i].pop_front()));
        end
      end
    end
  end
endmodule
